// File: rtl/fxp_div.sv
// Iterative unsigned fixed-point divider, q = (a << FRAC) / b, one quotient bit per cycle.
// Define DIV_ROUND_EN to add a round-half-up cycle after the quotient loop.
module fxp_div #(
  parameter int WIDTH = 6,
  parameter int FRAC  = 3
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             dz
);

  // state | meaning
  // IDLE  | ready for a new operand pair
  // CALC  | one restoring-division step per cycle
  // ROUND | round half up on the final remainder (DIV_ROUND_EN only)
  // DONE  | result held until the consumer takes it

  localparam int NW = WIDTH + FRAC;
  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t           state, state_nxt;
  logic [NW-1:0]    n_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [NW-1:0]    qf_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] r_nxt;
  logic [NW-1:0]    qf_nxt;

  // Saturate a widened quotient to WIDTH bits; returns {ovf, q}.
  function automatic logic [WIDTH:0] sat(input logic [NW:0] v);
    if (|v[NW:WIDTH]) sat = {1'b1, {WIDTH{1'b1}}};
    else              sat = {1'b0, v[WIDTH-1:0]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(NW - 1));

  // Remainder stays below b, so the WIDTH-bit truncation of r_nxt is lossless.
  assign r_sh   = {r_q, n_q[NW-1]};
  assign ge     = (r_sh >= {1'b0, b_q});
  assign r_nxt  = WIDTH'(ge ? (r_sh - {1'b0, b_q}) : r_sh);
  assign qf_nxt = {qf_q[NW-2:0], ge};

`ifdef DIV_ROUND_EN
  logic          up;
  logic [NW:0]   qr;
  assign up = ({r_q, 1'b0} >= {1'b0, b_q});
  assign qr = {1'b0, qf_q} + (NW+1)'(up);
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (b == '0) ? DONE : CALC;
      end
      CALC: begin
`ifdef DIV_ROUND_EN
        if (last) state_nxt = ROUND;
`else
        if (last) state_nxt = DONE;
`endif
      end
`ifdef DIV_ROUND_EN
      ROUND: state_nxt = DONE;
`endif
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      n_q  <= '0;
      b_q  <= '0;
      r_q  <= '0;
      qf_q <= '0;
      cnt  <= '0;
      q    <= '0;
      ovf  <= 1'b0;
      dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_q  <= {a, {FRAC{1'b0}}};
            b_q  <= b;
            r_q  <= '0;
            qf_q <= '0;
            cnt  <= '0;
            if (b == '0) begin
              q   <= '1;
              ovf <= 1'b0;
              dz  <= 1'b1;
            end else begin
              dz  <= 1'b0;
            end
          end
        end
        CALC: begin
          n_q  <= {n_q[NW-2:0], 1'b0};
          r_q  <= r_nxt;
          qf_q <= qf_nxt;
          cnt  <= cnt + CW'(1);
`ifndef DIV_ROUND_EN
          if (last) {ovf, q} <= sat({1'b0, qf_nxt});
`endif
        end
`ifdef DIV_ROUND_EN
        ROUND: {ovf, q} <= sat(qr);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div.sv
// Directed self-checking bench for fxp_div at default Q3.3; expectations follow DIV_ROUND_EN.
module tb_fxp_div;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] a = '0;
  logic [5:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] q;
  logic       ovf;
  logic       dz;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV_ROUND_EN
  localparam int LAT    = 10;
  localparam int Q_8_24 = 3;
  localparam int Q_1_3  = 3;
  localparam int Q_55_7 = 63;
`else
  localparam int LAT    = 9;
  localparam int Q_8_24 = 2;
  localparam int Q_1_3  = 2;
  localparam int Q_55_7 = 62;
`endif

  fxp_div #(.WIDTH(6), .FRAC(3)) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // elat = posedges after the accept edge until out_valid is seen (0: valid in the next cycle).
  task automatic run_op(input logic [5:0] xa, input logic [5:0] xb, input int eq,
                        input int eovf, input int edz, input int elat, input int hold);
    int lat;
    @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1;
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency %0d/%0d", xa, xb), lat, elat);
    chk($sformatf("q %0d/%0d", xa, xb), int'(q), eq);
    chk($sformatf("ovf %0d/%0d", xa, xb), int'(ovf), eovf);
    chk($sformatf("dz %0d/%0d", xa, xb), int'(dz), edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 6'd9; b = 6'd2;
      @(posedge clk); #1;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_q", int'(q), eq);
      chk("hold_ovf", int'(ovf), eovf);
      chk("hold_dz", int'(dz), edz);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_out_valid", int'(out_valid), 0);
    chk("take_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_dz", int'(dz), 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;

    run_op(6'd16, 6'd8,  16,     0, 0, LAT, 0);
    run_op(6'd8,  6'd16, 4,      0, 0, LAT, 0);
    run_op(6'd8,  6'd24, Q_8_24, 0, 0, LAT, 0);
    run_op(6'd63, 6'd1,  63,     1, 0, LAT, 0);
    run_op(6'd40, 6'd0,  63,     0, 1, 0,   0);
    run_op(6'd63, 6'd8,  63,     0, 0, LAT, 0);
    run_op(6'd63, 6'd7,  63,     1, 0, LAT, 0);
    run_op(6'd1,  6'd3,  Q_1_3,  0, 0, LAT, 0);
    run_op(6'd55, 6'd7,  Q_55_7, 0, 0, LAT, 0);
    run_op(6'd1,  6'd63, 0,      0, 0, LAT, 0);
    run_op(6'd5,  6'd3,  13,     0, 0, LAT, 0);
    run_op(6'd7,  6'd2,  28,     0, 0, LAT, 5);
    run_op(6'd10, 6'd4,  20,     0, 0, LAT, 0);

    // Reset in the middle of a calculation.
    @(negedge clk);
    a = 6'd63; b = 6'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_l = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_q", int'(q), 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("midrst_no_stale", seen, 0);
    run_op(6'd16, 6'd8, 16, 0, 0, LAT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
